// File: rtl/serializer_arbiter.sv
// -----------------------------------------------------------------------------
// serializer_arbiter
//
// Round-robin arbiter sharing a single serializer between NUM_REQ requesters.
// One winner per grant is captured into the ser_* registers and issued as a
// one-cycle ser_val_o pulse. All requesters are then held off until the
// serializer's busy flag falls. Lengths the serializer ignores (mod 1 and 2)
// are consumed and reported on drop_o, so no requester waits forever.
//
// Ports
//   clk_i        clock
//   arst_n_i     asynchronous active-low reset
//   req_data_i   packed requester words, requester k at [k*DATA_W +: DATA_W]
//   req_mod_i    packed requester lengths, k at [k*DATA_MOD_W +: DATA_MOD_W]
//   req_val_i    per-requester valid
//   req_ready_o  per-requester ready (one-hot or zero)
//   ser_data_o   word to the serializer
//   ser_mod_o    length to the serializer (0 = full DATA_W)
//   ser_val_o    single-cycle issue strobe to the serializer
//   ser_busy_i   serializer busy flag
//   grant_id_o   requester owning the current or last transfer
//   active_o     transfer issued or in flight
//   drop_o       one-cycle pulse: illegal-length request discarded
//   drop_id_o    requester index of the discarded request
// -----------------------------------------------------------------------------
module serializer_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DATA_MOD_W = 4,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data_i,
  input  logic [NUM_REQ*DATA_MOD_W-1:0]  req_mod_i,
  input  logic [NUM_REQ-1:0]             req_val_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [DATA_W-1:0]              ser_data_o,
  output logic [DATA_MOD_W-1:0]          ser_mod_o,
  output logic                           ser_val_o,
  input  logic                           ser_busy_i,
  output logic [ID_W-1:0]                grant_id_o,
  output logic                           active_o,
  output logic                           drop_o,
  output logic [ID_W-1:0]                drop_id_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_e;

  state_e                 state_q;
  logic [ID_W-1:0]        ptr_q;
  logic [ID_W-1:0]        ptr_d;
  logic [DATA_W-1:0]      ser_data_q;
  logic [DATA_MOD_W-1:0]  ser_mod_q;
  logic                   ser_val_q;
  logic [ID_W-1:0]        grant_id_q;
  logic                   drop_q;
  logic [ID_W-1:0]        drop_id_q;

  logic                   win_vld;
  logic [ID_W-1:0]        win_id;
  logic [DATA_W-1:0]      sel_data;
  logic [DATA_MOD_W-1:0]  sel_mod;
  logic                   mod_illegal;
  logic                   handshake;

  // Winner search: walk the priority order ptr, ptr+1, ... (mod NUM_REQ) and
  // keep the first valid requester.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!win_vld && req_val_i[ID_W'(idx)]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  // Word/length mux for the current winner.
  always_comb begin
    sel_data = '0;
    sel_mod  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == win_id) begin
        sel_data = req_data_i[k*DATA_W +: DATA_W];
        sel_mod  = req_mod_i[k*DATA_MOD_W +: DATA_MOD_W];
      end
    end
  end

  assign mod_illegal = (sel_mod == DATA_MOD_W'(1)) || (sel_mod == DATA_MOD_W'(2));

  // Ready is gated by the reset input directly so it is low throughout reset,
  // not only after the first clock edge.
  assign handshake = arst_n_i && (state_q == IDLE) && win_vld;

  always_comb begin
    req_ready_o = '0;
    if (handshake) begin
      req_ready_o[win_id] = 1'b1;
    end
  end

  assign ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      ser_data_q <= '0;
      ser_mod_q  <= '0;
      ser_val_q  <= 1'b0;
      grant_id_q <= '0;
      drop_q     <= 1'b0;
      drop_id_q  <= '0;
    end else begin
      ser_val_q <= 1'b0;
      drop_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (handshake) begin
            ptr_q <= ptr_d;
            if (mod_illegal) begin
              // Consumed but never issued: the serializer would ignore it.
              drop_q    <= 1'b1;
              drop_id_q <= win_id;
            end else begin
              ser_data_q <= sel_data;
              ser_mod_q  <= sel_mod;
              grant_id_q <= win_id;
              ser_val_q  <= 1'b1;
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!ser_busy_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ser_data_o = ser_data_q;
  assign ser_mod_o  = ser_mod_q;
  assign ser_val_o  = ser_val_q;
  assign grant_id_o = grant_id_q;
  assign drop_o     = drop_q;
  assign drop_id_o  = drop_id_q;
  assign active_o   = (state_q != IDLE);

endmodule

// File: tb/tb_serializer_arbiter.sv
module tb_serializer_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned DATA_MOD_W = 4;
  localparam int unsigned ID_W       = 2;

  logic                           clk;
  logic                           arst_n;
  logic [NUM_REQ*DATA_W-1:0]      req_data;
  logic [NUM_REQ*DATA_MOD_W-1:0]  req_mod;
  logic [NUM_REQ-1:0]             req_val;
  logic [NUM_REQ-1:0]             req_ready;
  logic [DATA_W-1:0]              ser_data;
  logic [DATA_MOD_W-1:0]          ser_mod;
  logic                           ser_val;
  logic                           ser_busy;
  logic [ID_W-1:0]                grant_id;
  logic                           active;
  logic                           drop;
  logic [ID_W-1:0]                drop_id;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  typedef struct {
    logic [ID_W-1:0]       id;
    logic [DATA_W-1:0]     data;
    logic [DATA_MOD_W-1:0] mod;
  } exp_t;

  exp_t            exp_q[$];
  logic [ID_W-1:0] drop_q[$];

  serializer_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .DATA_MOD_W (DATA_MOD_W)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .req_data_i  (req_data),
    .req_mod_i   (req_mod),
    .req_val_i   (req_val),
    .req_ready_o (req_ready),
    .ser_data_o  (ser_data),
    .ser_mod_o   (ser_mod),
    .ser_val_o   (ser_val),
    .ser_busy_i  (ser_busy),
    .grant_id_o  (grant_id),
    .active_o    (active),
    .drop_o      (drop),
    .drop_id_o   (drop_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural serializer: registered busy, one bit per busy cycle, MSB first.
  logic [DATA_W-1:0] sh_q;
  int unsigned       left_q;
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ser_busy <= 1'b0;
      left_q   <= 0;
      sh_q     <= '0;
    end else if (ser_val) begin
      sh_q     <= ser_data;
      left_q   <= (ser_mod == 4'd0) ? 32'd16 : 32'(ser_mod);
      ser_busy <= 1'b1;
    end else if (ser_busy) begin
      sh_q   <= sh_q << 1;
      left_q <= left_q - 1;
      if (left_q == 1) ser_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  logic        capture = 1'b0;
  logic [31:0] bits = '0;
  int          nbits = 0;
  logic        prev_val = 1'b0;
  always @(negedge clk) begin
    if (arst_n) begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (ser_val) begin
        exp_t e;
        pulses++;
        check("val_single_cycle", 32'(prev_val), 32'd0);
        check("val_not_while_busy", 32'(ser_busy), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 32'd1, 32'(exp_q.size()));
        end else begin
          e = exp_q.pop_front();
          check("sb_grant_id", 32'(grant_id), 32'(e.id));
          check("sb_data", 32'(ser_data), 32'(e.data));
          check("sb_mod", 32'(ser_mod), 32'(e.mod));
        end
      end
      if (drop) begin
        if (drop_q.size() == 0) begin
          check("unexpected_drop", 32'd1, 32'(drop_q.size()));
        end else begin
          check("sb_drop_id", 32'(drop_id), 32'(drop_q.pop_front()));
        end
      end
      if (capture && ser_busy) begin
        bits = (bits << 1) | 32'(sh_q[DATA_W-1]);
        nbits++;
      end
    end
    prev_val = ser_val;
  end

  task automatic set_req(input int k, input logic [DATA_W-1:0] d, input logic [DATA_MOD_W-1:0] m);
    req_data[k*DATA_W +: DATA_W]         = d;
    req_mod[k*DATA_MOD_W +: DATA_MOD_W]  = m;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (active !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(active), 32'd0);
  endtask

  initial begin
    int n;
    arst_n  = 1'b0;
    req_val = '1;
    req_data = '0;
    req_mod  = '0;
    for (int k = 0; k < 4; k++) set_req(k, 16'hD000 + 16'(k), 4'd0);

    // Reset with all requesters valid.
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_val", 32'(ser_val), 32'd0);
    check("rst_data", 32'(ser_data), 32'd0);
    check("rst_mod", 32'(ser_mod), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_drop_id", 32'(drop_id), 32'd0);
    check("rst_active", 32'(active), 32'd0);

    // Release: round robin 0,1,2,3,0 with all valid.
    exp_q.push_back('{id: 2'd0, data: 16'hD000, mod: 4'd0});
    exp_q.push_back('{id: 2'd1, data: 16'hD001, mod: 4'd0});
    exp_q.push_back('{id: 2'd2, data: 16'hD002, mod: 4'd0});
    exp_q.push_back('{id: 2'd3, data: 16'hD003, mod: 4'd0});
    exp_q.push_back('{id: 2'd0, data: 16'hD000, mod: 4'd0});
    arst_n = 1'b1;
    #1;
    check("rel_ready0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    check("rel_issue", 32'(ser_val), 32'd1);
    check("rel_active", 32'(active), 32'd1);
    check("rel_grant", 32'(grant_id), 32'd0);
    n = 0;
    while (pulses < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rr_five_issues", 32'(pulses), 32'd5);
    req_val = '0;
    wait_idle("rr_idle");
    check("rr_sb_empty", 32'(exp_q.size()), 32'd0);

    // Requester 2 alone, A5C3 length 5 (ptr now 1).
    set_req(2, 16'hA5C3, 4'd5);
    req_val = 4'b0100;
    exp_q.push_back('{id: 2'd2, data: 16'hA5C3, mod: 4'd5});
    bits = '0;
    nbits = 0;
    capture = 1'b1;
    #1;
    check("r2_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check("r2_issue", 32'(ser_val), 32'd1);
    req_val = '0;
    @(negedge clk);
    check("r2_busy_t2", 32'(ser_busy), 32'd1);
    check("r2_active_t2", 32'(active), 32'd1);
    wait_idle("r2_idle");
    capture = 1'b0;
    check("r2_busy_at_idle", 32'(ser_busy), 32'd0);
    check("r2_data_hold", 32'(ser_data), 32'hA5C3);
    check("r2_mod_hold", 32'(ser_mod), 32'd5);
    check("r2_nbits", 32'(nbits), 32'd5);
    check("r2_bits", bits, 32'b10100);

    // ptr=3, only requester 0 valid: wrap to 0, ptr becomes 1.
    req_val = 4'b0001;
    exp_q.push_back('{id: 2'd0, data: 16'hD000, mod: 4'd0});
    #1;
    check("wrap_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    check("wrap_grant", 32'(grant_id), 32'd0);
    req_val = '0;
    wait_idle("wrap_idle");

    // ptr should be 1: with 0 and 3 valid, 3 has priority.
    req_val = 4'b1001;
    #1;
    check("ptr1_peek", 32'(req_ready), 32'b1000);
    // Requester 1 illegal mod 2, requester 3 legal.
    set_req(1, 16'hBEEF, 4'd2);
    set_req(3, 16'hD003, 4'd0);
    req_val = 4'b1010;
    drop_q.push_back(2'd1);
    exp_q.push_back('{id: 2'd3, data: 16'hD003, mod: 4'd0});
    #1;
    check("drop_ready_t", 32'(req_ready), 32'b0010);
    @(negedge clk);
    check("drop_pulse", 32'(drop), 32'd1);
    check("drop_id", 32'(drop_id), 32'd1);
    check("drop_no_issue", 32'(ser_val), 32'd0);
    check("drop_still_idle", 32'(active), 32'd0);
    req_val = 4'b1000;
    #1;
    check("drop_r3_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    check("drop_r3_issue", 32'(ser_val), 32'd1);
    check("drop_r3_grant", 32'(grant_id), 32'd3);
    check("drop_pulse_end", 32'(drop), 32'd0);
    req_val = '0;
    wait_idle("drop_idle");

    // Reset asserted mid-transfer in WAIT_DONE (ptr now 0).
    set_req(1, 16'hD001, 4'd0);
    req_val = 4'b0010;
    exp_q.push_back('{id: 2'd1, data: 16'hD001, mod: 4'd0});
    @(negedge clk);
    req_val = '0;
    @(negedge clk);
    check("mid_active", 32'(active), 32'd1);
    check("mid_busy", 32'(ser_busy), 32'd1);
    arst_n = 1'b0;
    req_val = 4'b1110;
    #1;
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_val", 32'(ser_val), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_grant", 32'(grant_id), 32'd0);
    check("mid_rst_data", 32'(ser_data), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    exp_q.push_back('{id: 2'd1, data: 16'hD001, mod: 4'd0});
    #1;
    check("post_rst_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    check("post_rst_issue", 32'(ser_val), 32'd1);
    check("post_rst_grant", 32'(grant_id), 32'd1);
    req_val = '0;
    wait_idle("post_rst_idle");

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check("final_drop_empty", 32'(drop_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
